reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_pkg.sv | 18 +
 rtl/rr_pick.sv | 39 +++
 rtl/reg_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus arbiter.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
package reg_bus_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NREQ_DEF   = 4;
  localparam int DEST_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: round-robin from last+1, or
// lowest-index-first when ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import reg_bus_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]   last,
`endif
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW-1:0] j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      j = IW'(k);
`else
      j = IW'((int'(last) + 1 + k) % NREQ);
`endif
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates per-requester latch write/clear ops onto a shared bus.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NREQ   = NREQ_DEF,
  parameter  int DEST_W = DEST_W_DEF,
  localparam int NDEST  = 2**DEST_W,
  localparam int IW     = idx_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          clr,
  input  logic [NREQ*DEST_W-1:0]   dest,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         bus_data,
  output logic [NDEST-1:0]         latch_set,
  output logic [NDEST-1:0]         latch_reset,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  bus_q, bus_d;
  logic [NDEST-1:0]  set_q, set_d;
  logic [NDEST-1:0]  rst_q, rst_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   win;
  logic [IW-1:0]     win_idx;
  logic              any;
  logic [DEST_W-1:0] sel_dest;
  logic [WIDTH-1:0]  sel_wdata;
  logic              sel_clr;

`ifndef ARB_FIXED_PRIO_EN
  logic [IW-1:0]     last_q, last_d;
`endif

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req     (req),
`ifndef ARB_FIXED_PRIO_EN
    .last    (last_q),
`endif
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  always_comb begin
    sel_dest  = dest[int'(win_idx)*DEST_W +: DEST_W];
    sel_wdata = wdata[int'(win_idx)*WIDTH +: WIDTH];
    sel_clr   = clr[win_idx];
  end

  // Outputs are loaded on the capture edge so they are live during ISSUE.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    set_d   = '0;
    rst_d   = '0;
    busy_d  = 1'b0;
    bus_d   = bus_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = ISSUE;
          gnt_d   = win;
          busy_d  = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = win_idx;
`endif
          if (sel_clr) begin
            rst_d = NDEST'(1) << sel_dest;
            bus_d = '0;
          end else begin
            set_d = NDEST'(1) << sel_dest;
            bus_d = sel_wdata;
          end
        end
      end
      ISSUE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      bus_q   <= '0;
      set_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= IW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      bus_q   <= bus_d;
      set_q   <= set_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign bus_data    = bus_q;
  assign latch_set   = set_q;
  assign latch_reset = rst_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: directed ops queue expected
// ISSUE cycles; a negedge monitor pops and compares them.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, clr;
  logic [11:0] dest;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  bus_data, latch_set, latch_reset;
  logic        busy;

  reg_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .clr         (clr),
    .dest        (dest),
    .wdata       (wdata),
    .gnt         (gnt),
    .bus_data    (bus_data),
    .latch_set   (latch_set),
    .latch_reset (latch_reset),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_bus = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] s,
                      input logic [7:0] r, input logic [7:0] b,
                      input int c);
    exp_t e;
    e.g = g; e.s = s; e.r = r; e.b = b; e.c = c;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic c,
                         input logic [2:0] d, input logic [7:0] w);
    clr[i]          = c;
    dest[i*3 +: 3]  = d;
    wdata[i*8 +: 8] = w;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Hold requests, dropping each bit on its grant, bounded wait.
  task automatic drain();
    int n;
    n = 0;
    while (req != 4'b0 && n < 40) begin
      @(negedge clk);
      req = req & ~gnt;
      n++;
    end
    if (req != 4'b0) begin
      chk("drain_timeout", {28'b0, req}, 32'h0);
      req = 4'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", {28'b0, gnt}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("gnt", {28'b0, gnt}, {28'b0, e.g});
          chk("latch_set", {24'b0, latch_set}, {24'b0, e.s});
          chk("latch_reset", {24'b0, latch_reset}, {24'b0, e.r});
          chk("bus_data", {24'b0, bus_data}, {24'b0, e.b});
          chk("issue_cycle", cyc, e.c);
          exp_bus = e.b;
        end
      end else begin
        chk("idle_strobes", {12'b0, gnt, latch_set, latch_reset}, 32'h0);
        chk("idle_bus", {24'b0, bus_data}, {24'b0, exp_bus});
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    clr   = '0;
    dest  = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    chk("rst_set", {24'b0, latch_set}, 32'h0);
    chk("rst_reset", {24'b0, latch_reset}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_bus", {24'b0, bus_data}, 32'h0);
    #2 reset = 1'b0;

    // single write: req2 dest5 data A5
    sync();
    set_req(2, 1'b0, 3'd5, 8'hA5);
    push(4'b0100, 8'h20, 8'h00, 8'hA5, cyc + 1);
    req = 4'b0100;
    drain();

    // clear: req1 dest7
    sync();
    set_req(1, 1'b1, 3'd7, 8'h3C);
    push(4'b0010, 8'h00, 8'h80, 8'h00, cyc + 1);
    req = 4'b0010;
    drain();

    // reset pulse so the rotation starts at requester 0
    sync();
    reset = 1'b1;
    exp_bus = 8'h00;
    #3 reset = 1'b0;

    // all four held: 0,1,2,3 every second cycle
    sync();
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b0, 3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++)
      push(4'(1 << i), 8'(1 << i), 8'h00, 8'h10 + 8'(i), cyc + 1 + 2*i);
    req = 4'b1111;
    drain();

    // requester 0 alone, then 0 and 2 together
    sync();
    set_req(0, 1'b0, 3'd1, 8'h5A);
    push(4'b0001, 8'h02, 8'h00, 8'h5A, cyc + 1);
    req = 4'b0001;
    drain();
    sync();
    set_req(0, 1'b1, 3'd2, 8'h99);
    set_req(2, 1'b0, 3'd4, 8'hC3);
`ifdef ARB_FIXED_PRIO_EN
    push(4'b0001, 8'h00, 8'h04, 8'h00, cyc + 1);
    push(4'b0100, 8'h10, 8'h00, 8'hC3, cyc + 3);
`else
    push(4'b0100, 8'h10, 8'h00, 8'hC3, cyc + 1);
    push(4'b0001, 8'h00, 8'h04, 8'h00, cyc + 3);
`endif
    req = 4'b0101;
    drain();

    // inputs change after capture
    sync();
    set_req(0, 1'b0, 3'd3, 8'h11);
    push(4'b0001, 8'h08, 8'h00, 8'h11, cyc + 1);
    req = 4'b0001;
    sync();
    set_req(0, 1'b1, 3'd6, 8'h22);
    req = 4'b0000;
    repeat (3) @(posedge clk);

    // boundary: dest 0, data FF, top requester
    sync();
    set_req(3, 1'b0, 3'd0, 8'hFF);
    push(4'b1000, 8'h01, 8'h00, 8'hFF, cyc + 1);
    req = 4'b1000;
    drain();

    // request withdrawn before capture: no grant expected
    sync();
    set_req(3, 1'b0, 3'd2, 8'h44);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    repeat (4) @(posedge clk);

    // async reset during ISSUE abandons the op
    sync();
    set_req(0, 1'b0, 3'd6, 8'h77);
    req = 4'b0001;
    @(posedge clk);
    #2 reset = 1'b1;
    req = 4'b0000;
    #1;
    chk("arst_set", {24'b0, latch_set}, 32'h0);
    chk("arst_gnt", {28'b0, gnt}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_bus", {24'b0, bus_data}, 32'h0);
    exp_bus = 8'h00;
    #5 reset = 1'b0;

    // after release requester 0 must win first
    sync();
    set_req(0, 1'b0, 3'd6, 8'h66);
    set_req(1, 1'b0, 3'd5, 8'h55);
    push(4'b0001, 8'h40, 8'h00, 8'h66, cyc + 1);
    push(4'b0010, 8'h20, 8'h00, 8'h55, cyc + 3);
    req = 4'b0011;
    drain();

    repeat (4) @(posedge clk);
    chk("pending_expected", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
